// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
package fifo_rd_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_PTR_W = 1;
  localparam int unsigned SKID_OCC_W = 2;
  localparam int unsigned RD_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [RD_DATA_W-1:0] data;
    logic                 last;
  } skid_entry_t;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry valid/ready output buffer holding {data, last}, with occupancy.
// The writer guarantees it never writes while full.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  skid_entry_t           wr_entry,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output skid_entry_t           rd_entry,
  output logic [SKID_OCC_W-1:0] occupancy
);

  skid_entry_t           r_mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] r_wptr;
  logic [SKID_PTR_W-1:0] r_rptr;
  logic [SKID_OCC_W-1:0] r_count;
  logic                  w_pop;

  assign rd_valid  = (r_count != '0);
  assign w_pop     = rd_valid & rd_ready;
  assign rd_entry  = r_mem[r_rptr];
  assign occupancy = r_count;

  // Storage, pointers and count; clear wipes entries so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (wr_en) begin
        r_mem[r_wptr] <= wr_entry;
        r_wptr        <= r_wptr + SKID_PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + SKID_PTR_W'(1);
      r_count <= r_count + SKID_OCC_W'(wr_en) - SKID_OCC_W'(w_pop);
    end
  end

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-domain FIFO drain: pops bursts of BURST_LEN words (or a partial burst
// on flush), absorbs the one-cycle read latency and streams words out with an
// end-of-burst marker. Optional FIFO_RD_UNDERFLOW_CNT_EN adds a saturating
// underflow pulse counter on port underflow_cnt.
module fifo_read_streamer
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = RD_DATA_W,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned BURST_LEN     = 4
) (
  input  logic                   rclk,
  input  logic                   hw_rst_n,
  input  logic                   sw_rst,
  input  logic                   rdempty,
  input  logic [ADDRESS_WIDTH:0] rd_level,
  input  logic [DATA_WIDTH-1:0]  read_data,
  input  logic                   underflow,
  output logic                   read_enable,
  input  logic                   flush,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   err_underflow
`ifdef FIFO_RD_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]            underflow_cnt
`endif
);

  localparam int unsigned LVL_W = ADDRESS_WIDTH + 1;

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [LVL_W-1:0]      r_len;
  logic [LVL_W-1:0]      w_len_nxt;
  logic [LVL_W-1:0]      r_issued;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic                  r_err;
  logic                  w_issue;
  logic                  w_room;
  logic                  w_pop;
  logic [SKID_OCC_W-1:0] w_occ;
  skid_entry_t           w_wr_entry;
  skid_entry_t           w_rd_entry;

  // A pop in the same cycle frees a slot, which keeps 1 word/cycle sustained.
  assign w_pop   = m_valid & m_ready;
  assign w_room  = (3'(w_occ) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));
  assign w_issue = (r_state != IDLE) & (r_issued < r_len) & ~rdempty & w_room & ~sw_rst;

  assign read_enable   = w_issue;
  assign busy          = (r_state != IDLE) | (w_occ != '0);
  assign err_underflow = r_err;

  // State and latched burst length.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Next-state: full burst beats flush; len is frozen once a burst starts.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    case (r_state)
      IDLE: begin
        if (rd_level >= LVL_W'(BURST_LEN)) begin
          w_state_nxt = BURST;
          w_len_nxt   = LVL_W'(BURST_LEN);
        end else if (flush && !rdempty) begin
          w_state_nxt = FLUSH;
          w_len_nxt   = rd_level;
        end
      end
      BURST, FLUSH: begin
        if (r_issued == r_len) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (sw_rst) begin
      w_state_nxt = IDLE;
      w_len_nxt   = '0;
    end
  end

  // Issue counter and the single in-flight read with its last tag.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n) begin
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (sw_rst) begin
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      if (r_state == IDLE) r_issued <= '0;
      else if (w_issue)    r_issued <= r_issued + LVL_W'(1);
      r_inflight      <= w_issue;
      r_inflight_last <= (LVL_W'(r_issued + LVL_W'(1)) == r_len);
    end
  end

  // Sticky underflow flag.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n)      r_err <= 1'b0;
    else if (sw_rst)    r_err <= 1'b0;
    else if (underflow) r_err <= 1'b1;
  end

`ifdef FIFO_RD_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_cnt;

  // Saturating count of underflow pulses.
  always_ff @(posedge rclk or negedge hw_rst_n) begin
    if (!hw_rst_n)                            r_uf_cnt <= '0;
    else if (sw_rst)                          r_uf_cnt <= '0;
    else if (underflow && r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
  end

  assign underflow_cnt = r_uf_cnt;
`endif

  assign w_wr_entry.data = RD_DATA_W'(read_data);
  assign w_wr_entry.last = r_inflight_last;

  fifo_rd_skid_buf u_skid (
    .clk       (rclk),
    .rst_n     (hw_rst_n),
    .clr       (sw_rst),
    .wr_en     (r_inflight & ~sw_rst),
    .wr_entry  (w_wr_entry),
    .rd_ready  (m_ready),
    .rd_valid  (m_valid),
    .rd_entry  (w_rd_entry),
    .occupancy (w_occ)
  );

  assign m_data = DATA_WIDTH'(w_rd_entry.data);
  assign m_last = w_rd_entry.last;

endmodule
